// File: rtl/object_pixel_mapper_pkg.sv
// Shared object-state definitions: coordinate width, field indices and
// the packed object record exchanged with the upstream object controller.
package object_pixel_mapper_pkg;

   localparam int COORD_W = 11;

   localparam int IMG_ID = 0;
   localparam int X      = 1;
   localparam int Y      = 2;
   localparam int WIDTH  = 3;
   localparam int HEIGHT = 4;

   typedef logic [0:4][0:COORD_W-1] object_state_t;

endpackage

// File: rtl/object_pixel_mapper_if.sv
// Pixel/object bus between the video timing source and the mapper.
// master: drives frame_start, object_state, pixel stream; slave: returns results.
interface object_pixel_mapper_if #(
   parameter int COORD_W = 11
);

   logic                       frame_start;
   logic [0:4][0:COORD_W-1]    object_state;
   logic                       pixel_valid;
   logic [COORD_W-1:0]         pixelX;
   logic [COORD_W-1:0]         pixelY;
   logic                       valid_out;
   logic                       draw_request;
   logic [COORD_W-1:0]         offsetX;
   logic [COORD_W-1:0]         offsetY;
   logic [COORD_W-1:0]         img_id_out;

   modport master (
      output frame_start, object_state, pixel_valid, pixelX, pixelY,
      input  valid_out, draw_request, offsetX, offsetY, img_id_out
   );

   modport slave (
      input  frame_start, object_state, pixel_valid, pixelX, pixelY,
      output valid_out, draw_request, offsetX, offsetY, img_id_out
   );

endinterface

// File: rtl/object_pixel_mapper_span_check.sv
// One-axis span test: hit when start <= coord < start+len (no wrap).
// Ports: start_i, len_i, coord_i -> hit_o, offset_o = coord - start.
module span_check #(
   parameter int W = 11
) (
   input  logic [W-1:0] start_i,
   input  logic [W-1:0] len_i,
   input  logic [W-1:0] coord_i,
   output logic         hit_o,
   output logic [W-1:0] offset_o
);

   // One extra bit so start+len never wraps back onto the screen.
   logic [W:0] end_w;

   assign end_w    = {1'b0, start_i} + {1'b0, len_i};
   assign hit_o    = (coord_i >= start_i) && ({1'b0, coord_i} < end_w);
   assign offset_o = coord_i - start_i;

endmodule

// File: rtl/object_pixel_mapper.sv
// Maps screen pixels to bitmap offsets of a single frame-latched object.
// Ports: clk, reset (async high), bus (slave): pixel in, 2-cycle result out.
module object_pixel_mapper #(
   parameter int COORD_W = 11,
   parameter bit WRAP_Y  = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   object_pixel_mapper_if.slave bus
);

   import object_pixel_mapper_pkg::*;

   localparam logic [0:0] ST_DISARMED = 1'b0;
   localparam logic [0:0] ST_ARMED    = 1'b1;

   logic [0:4][0:COORD_W-1] shadow_q;
   logic [0:4][0:COORD_W-1] shadow_d;
   logic [0:0]              st_q;
   logic [0:0]              st_d;

   logic                    hit_x;
   logic                    hit_y;
   logic [COORD_W-1:0]      off_x;
   logic [COORD_W-1:0]      off_y;

   logic                    s1_valid_q, s1_valid_d;
   logic                    s1_draw_q,  s1_draw_d;
   logic [COORD_W-1:0]      s1_offx_q,  s1_offx_d;
   logic [COORD_W-1:0]      s1_offy_q,  s1_offy_d;
   logic [COORD_W-1:0]      s1_img_q,   s1_img_d;

   logic                    s2_valid_q;
   logic                    s2_draw_q;
   logic [COORD_W-1:0]      s2_offx_q;
   logic [COORD_W-1:0]      s2_offy_q;
   logic [COORD_W-1:0]      s2_img_q;

   // Shadow and arm state only change on frame_start; the pixel of that
   // same cycle still sees the previous values.
   always_comb begin
      shadow_d = shadow_q;
      st_d     = st_q;
      if (bus.frame_start) begin
         shadow_d = bus.object_state;
         st_d     = ST_ARMED;
      end
   end

   span_check #(.W(COORD_W)) u_span_x (
      .start_i  (shadow_q[X]),
      .len_i    (shadow_q[WIDTH]),
      .coord_i  (bus.pixelX),
      .hit_o    (hit_x),
      .offset_o (off_x)
   );

   if (WRAP_Y) begin : g_wrap
      logic [COORD_W-1:0] dy;
      logic [COORD_W-1:0] mask;
      // Height is a power of two, so the modulo reduces to a mask.
      assign dy    = bus.pixelY - shadow_q[Y];
      assign mask  = shadow_q[HEIGHT] - {{(COORD_W-1){1'b0}}, 1'b1};
      assign hit_y = (shadow_q[HEIGHT] != '0);
      assign off_y = dy & mask;
   end else begin : g_span
      span_check #(.W(COORD_W)) u_span_y (
         .start_i  (shadow_q[Y]),
         .len_i    (shadow_q[HEIGHT]),
         .coord_i  (bus.pixelY),
         .hit_o    (hit_y),
         .offset_o (off_y)
      );
   end

   always_comb begin
      s1_valid_d = bus.pixel_valid;
      s1_draw_d  = bus.pixel_valid && (st_q == ST_ARMED) && hit_x && hit_y;
      s1_offx_d  = off_x;
      s1_offy_d  = off_y;
      s1_img_d   = shadow_q[IMG_ID];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q   <= '0;
         st_q       <= ST_DISARMED;
         s1_valid_q <= 1'b0;
         s1_draw_q  <= 1'b0;
         s1_offx_q  <= '0;
         s1_offy_q  <= '0;
         s1_img_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_draw_q  <= 1'b0;
         s2_offx_q  <= '0;
         s2_offy_q  <= '0;
         s2_img_q   <= '0;
      end else begin
         shadow_q   <= shadow_d;
         st_q       <= st_d;
         s1_valid_q <= s1_valid_d;
         s1_draw_q  <= s1_draw_d;
         s1_offx_q  <= s1_offx_d;
         s1_offy_q  <= s1_offy_d;
         s1_img_q   <= s1_img_d;
         s2_valid_q <= s1_valid_q;
         s2_draw_q  <= s1_draw_q;
         s2_offx_q  <= s1_offx_q;
         s2_offy_q  <= s1_offy_q;
         s2_img_q   <= s1_img_q;
      end
   end

   assign bus.valid_out    = s2_valid_q;
   assign bus.draw_request = s2_draw_q;
   assign bus.offsetX      = s2_offx_q;
   assign bus.offsetY      = s2_offy_q;
   assign bus.img_id_out   = s2_img_q;

endmodule

// File: tb/tb_object_pixel_mapper.sv
// Directed bench for object_pixel_mapper (WRAP_Y=1): vector table plus
// hand-written frame_start-collision and mid-flight reset sequences.
module tb_object_pixel_mapper;

   localparam int W = 11;

   logic clk;
   logic reset;

   object_pixel_mapper_if #(.COORD_W(W)) bus ();

   object_pixel_mapper #(.COORD_W(W), .WRAP_Y(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         pv;
      logic [W-1:0] px;
      logic [W-1:0] py;
      logic         ev;
      logic         ed;
      logic         co;
      logic [W-1:0] ox;
      logic [W-1:0] oy;
      logic [W-1:0] img;
   } vec_t;

   vec_t tv[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic add(input logic pv, input int px, input int py,
                      input logic ev, input logic ed, input logic co,
                      input int ox, input int oy, input int img);
      vec_t v;
      v.pv = pv; v.px = W'(px); v.py = W'(py);
      v.ev = ev; v.ed = ed; v.co = co;
      v.ox = W'(ox); v.oy = W'(oy); v.img = W'(img);
      tv.push_back(v);
   endtask

   task automatic pix(input logic pv, input int px, input int py);
      bus.pixel_valid = pv;
      bus.pixelX      = W'(px);
      bus.pixelY      = W'(py);
   endtask

   task automatic set_state(input int id, input int x, input int y,
                            input int w, input int h);
      bus.object_state = {W'(id), W'(x), W'(y), W'(w), W'(h)};
   endtask

   task automatic chk_out(input string tag, input logic ev, input logic ed,
                          input logic co, input logic [W-1:0] ox,
                          input logic [W-1:0] oy, input logic [W-1:0] img);
      chk({tag, ".valid"}, 32'(bus.valid_out), 32'(ev));
      chk({tag, ".draw"},  32'(bus.draw_request), 32'(ed));
      if (co) begin
         chk({tag, ".offX"}, 32'(bus.offsetX), 32'(ox));
         chk({tag, ".offY"}, 32'(bus.offsetY), 32'(oy));
         chk({tag, ".img"},  32'(bus.img_id_out), 32'(img));
      end
   endtask

   task automatic run_vecs(input string tag);
      int n;
      n = tv.size();
      for (int i = 0; i < n + 2; i++) begin
         @(negedge clk);
         if (i >= 2)
            chk_out($sformatf("%s[%0d]", tag, i - 2), tv[i-2].ev, tv[i-2].ed,
                    tv[i-2].co, tv[i-2].ox, tv[i-2].oy, tv[i-2].img);
         if (i < n) pix(tv[i].pv, int'(tv[i].px), int'(tv[i].py));
         else       pix(1'b0, 0, 0);
      end
      tv.delete();
   endtask

   task automatic load_frame(input int id, input int x, input int y,
                             input int w, input int h);
      @(negedge clk);
      set_state(id, x, y, w, h);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
   endtask

   initial begin
      reset            = 1'b1;
      bus.frame_start  = 1'b0;
      bus.object_state = '0;
      pix(1'b0, 0, 0);
      set_state(9, 1, 1, 4, 4);

      repeat (2) @(negedge clk);
      chk_out("reset", 1'b0, 1'b0, 1'b1, '0, '0, '0);
      reset = 1'b0;

      add(1, 106, 7, 1, 0, 0, 0, 0, 0);
      add(1, 200, 20, 1, 0, 0, 0, 0, 0);
      add(0, 106, 7, 0, 0, 0, 0, 0, 0);
      add(1, 110, 9, 1, 0, 0, 0, 0, 0);
      run_vecs("disarmed");

      load_frame(5, 106, 7, 318, 32);

      add(1, 106, 7,   1, 1, 1, 0,   0,  5);
      add(1, 423, 7,   1, 1, 1, 317, 0,  5);
      add(1, 424, 7,   1, 0, 0, 0,   0,  0);
      add(1, 105, 7,   1, 0, 0, 0,   0,  0);
      add(1, 106, 5,   1, 1, 1, 0,   30, 5);
      add(1, 106, 40,  1, 1, 1, 0,   1,  5);
      add(1, 106, 327, 1, 1, 1, 0,   0,  5);
      add(0, 200, 10,  0, 0, 0, 0,   0,  0);
      add(1, 300, 2047, 1, 1, 1, 194, 24, 5);
      run_vecs("map");

      load_frame(6, 10, 0, 0, 16);
      add(1, 10, 3, 1, 0, 0, 0, 0, 0);
      add(1, 11, 3, 1, 0, 0, 0, 0, 0);
      run_vecs("zero_w");

      load_frame(5, 106, 7, 318, 32);
      @(negedge clk);
      set_state(5, 106, 8, 318, 32);
      bus.frame_start = 1'b1;
      pix(1'b1, 106, 7);
      @(negedge clk);
      bus.frame_start = 1'b0;
      pix(1'b1, 106, 7);
      @(negedge clk);
      pix(1'b0, 0, 0);
      chk_out("fs_same", 1'b1, 1'b1, 1'b1, '0, W'(0), W'(5));
      @(negedge clk);
      chk_out("fs_next", 1'b1, 1'b1, 1'b1, '0, W'(31), W'(5));

      @(negedge clk);
      pix(1'b1, 106, 7);
      @(negedge clk);
      pix(1'b1, 120, 9);
      #2 reset = 1'b1;
      #1 chk_out("rst_async", 1'b0, 1'b0, 1'b1, '0, '0, '0);
      @(negedge clk);
      pix(1'b0, 0, 0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_out($sformatf("post_rst[%0d]", i), 1'b0, 1'b0, 1'b1,
                 '0, '0, '0);
      end

      add(1, 106, 7, 1, 0, 0, 0, 0, 0);
      run_vecs("rst_disarm");

      load_frame(3, 0, 0, 8, 8);
      add(1, 5, 6, 1, 1, 1, 5, 6, 3);
      add(1, 8, 6, 1, 0, 0, 0, 0, 0);
      run_vecs("rearm");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
